// File: rtl/seq_frame_pkg.sv
// Shared definitions for the 10010 serial frame transmitter.
//   SYNC_W / SYNC_WORD : sync pattern that precedes every payload (sent MSB first)
//   frame_state_e      : transmitter state encoding (IDLE/SYNC/DATA/GAP = 00/01/10/11)
//   cnt_width()        : width of the shared bit/gap counter for a given configuration
package seq_frame_pkg;

  localparam int                SYNC_W    = 5;
  localparam logic [SYNC_W-1:0] SYNC_WORD = 5'b10010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SYNC = 2'b01,
    DATA = 2'b10,
    GAP  = 2'b11
  } frame_state_e;

  // The counter is always loaded with (length - 1), so clog2 of the largest
  // length is enough to hold every load value without wrapping.
  function automatic int cnt_width(input int payload_w, input int gap_cycles);
    int m;
    m = payload_w;
    if (gap_cycles > m) m = gap_cycles;
    if (SYNC_W > m)     m = SYNC_W;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/seq_10010_frame_tx_piso.sv
// Parallel-in serial-out shift register, MSB first.
//   clk   : clock
//   reset : asynchronous active-low reset, clears the register
//   load  : capture din (has priority over shift)
//   shift : move every bit one place towards the MSB, zero-filling the LSB
//   din   : parallel word to capture
//   msb   : current most significant bit (next bit to be sent)
module piso_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] data_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= din;
    end else if (shift) begin
      data_reg <= data_reg << 1;
    end
  end

  assign msb = data_reg[W-1];

endmodule

// File: rtl/seq_10010_frame_tx.sv
// Serial frame transmitter: accepts a payload word over valid/ready and sends
// sync word 10010, then the payload (both MSB first), then GAP_CYCLES zeros.
//   clk         : clock, all state changes on the rising edge
//   reset       : asynchronous active-low reset
//   in_data     : payload word, captured when in_valid & in_ready
//   in_valid    : in_data is valid
//   in_ready    : transmitter is idle and can accept a word this cycle
//   dout        : serial bit stream
//   dout_valid  : dout carries a sync or payload bit
//   frame_start : pulse with the first sync bit
//   frame_done  : pulse with the last payload bit
//   busy        : transmitter is not idle
module seq_10010_frame_tx
  import seq_frame_pkg::*;
#(
  parameter int PAYLOAD_W  = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 dout,
  output logic                 dout_valid,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int CNT_W      = cnt_width(PAYLOAD_W, GAP_CYCLES);
  localparam int SYNC_IDX_W = $clog2(SYNC_W);

  if (PAYLOAD_W < 1 || PAYLOAD_W > 32) begin : g_bad_payload_w
    $error("seq_10010_frame_tx: PAYLOAD_W must be in 1..32");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap_cycles
    $error("seq_10010_frame_tx: GAP_CYCLES must be in 0..255");
  end

  frame_state_e     state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             dout_reg, dout_next;
  logic             dout_valid_reg, dout_valid_next;
  logic             frame_start_reg, frame_start_next;
  logic             frame_done_reg, frame_done_next;
  logic             busy_reg, busy_next;
  logic             load, shift, payload_msb;

  piso_shift_reg #(
    .W (PAYLOAD_W)
  ) u_payload (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .din   (in_data),
    .msb   (payload_msb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      dout_reg        <= 1'b0;
      dout_valid_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      dout_reg        <= dout_next;
      dout_valid_reg  <= dout_valid_next;
      frame_start_reg <= frame_start_next;
      frame_done_reg  <= frame_done_next;
      busy_reg        <= busy_next;
    end
  end

  // cnt_reg holds the index of the bit currently on dout (SYNC/DATA) or the
  // number of gap cycles still to follow (GAP).
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next = SYNC;
          cnt_next   = CNT_W'(SYNC_W - 1);
          load       = 1'b1;
        end
      end
      SYNC: begin
        if (cnt_reg == '0) begin
          state_next = DATA;
          cnt_next   = CNT_W'(PAYLOAD_W - 1);
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_reg == '0) begin
          if (GAP_CYCLES > 0) begin
            state_next = GAP;
            cnt_next   = CNT_W'(GAP_CYCLES - 1);
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the next state: the bit
  // registered into dout is the one belonging to the cycle being entered.
  // The payload register shifts as its MSB is consumed, so each DATA cycle
  // takes the MSB first and advances the register in the same edge.
  always_comb begin
    dout_next        = 1'b0;
    shift            = (state_next == DATA);
    dout_valid_next  = (state_next == SYNC) || (state_next == DATA);
    frame_start_next = load;
    frame_done_next  = (state_next == DATA) && (cnt_next == '0);
    busy_next        = (state_next != IDLE);
    if (state_next == SYNC) begin
      dout_next = SYNC_WORD[cnt_next[SYNC_IDX_W-1:0]];
    end else if (state_next == DATA) begin
      dout_next = payload_msb;
    end
  end

  assign in_ready    = (state_reg == IDLE);
  assign dout        = dout_reg;
  assign dout_valid  = dout_valid_reg;
  assign frame_start = frame_start_reg;
  assign frame_done  = frame_done_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_seq_10010_frame_tx.sv
// Bench for seq_10010_frame_tx: an 8-bit/gap-2 instance driven from a vector
// table and hand-written corner sequences, and a 1-bit/gap-0 instance used for
// the loopback and minimum-period run. Expected bit streams go into a
// scoreboard queue when a word is offered and are popped as bits appear.
module tb_seq_10010_frame_tx;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 8-bit payload, 2 gap cycles
  logic [7:0] in_data_a;
  logic       in_valid_a, in_ready_a, dout_a, dout_valid_a;
  logic       frame_start_a, frame_done_a, busy_a;
  // 1-bit payload, no gap
  logic [0:0] in_data_b;
  logic       in_valid_b, in_ready_b, dout_b, dout_valid_b;
  logic       frame_start_b, frame_done_b, busy_b;

  seq_10010_frame_tx #(.PAYLOAD_W(8), .GAP_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .in_data(in_data_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .dout(dout_a), .dout_valid(dout_valid_a),
    .frame_start(frame_start_a), .frame_done(frame_done_a), .busy(busy_a)
  );

  seq_10010_frame_tx #(.PAYLOAD_W(1), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .in_data(in_data_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .dout(dout_b), .dout_valid(dout_valid_b),
    .frame_start(frame_start_b), .frame_done(frame_done_b), .busy(busy_b)
  );

  typedef struct packed {
    logic b;  // expected dout
    logic s;  // expected frame_start
    logic d;  // expected frame_done
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic [12:0] stream;  // sync + payload, first bit in the MSB
  } vec_t;

  exp_t sbq_a[$];
  exp_t sbq_b[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_done_a = 0;
  int done_cnt_a = 0;
  int prev_start_b = -1;
  int det_a = 0;
  int det_b = 0;
  bit mon_en = 1'b0;
  bit lb_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event did not occur in time (cycle %0d)", name, cyc);
  endtask

  task automatic push_a(input logic [12:0] stream);
    exp_t e;
    for (int i = 0; i < 13; i++) begin
      e.b = stream[12-i];
      e.s = (i == 0);
      e.d = (i == 12);
      sbq_a.push_back(e);
    end
  endtask

  task automatic push_b(input logic [5:0] stream);
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      e.b = stream[5-i];
      e.s = (i == 0);
      e.d = (i == 5);
      sbq_b.push_back(e);
    end
  endtask

  function automatic int count_pat(input logic [12:0] s);
    int n = 0;
    for (int i = 12; i >= 4; i--) if (s[i -: 5] == 5'b10010) n++;
    return n;
  endfunction

  // Called at #1 after a rising edge; returns at #1 after the acceptance edge.
  task automatic send_a(input logic [7:0] d, input logic [12:0] stream);
    int n = 0;
    in_data_a  = d;
    in_valid_a = 1'b1;
    while (!in_ready_a && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready_a) begin
      fail_now("a_accept_timeout");
    end else begin
      push_a(stream);
      $display("tx_a accept data=%02h cycle=%0d", d, cyc);
      @(posedge clk); #1;
    end
    in_valid_a = 1'b0;
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while ((busy_a || sbq_a.size() != 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (busy_a || sbq_a.size() != 0) fail_now("a_idle_timeout");
  endtask

  // Scoreboard / protocol monitor, instance A
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (mon_en) begin
      check("a_ready_vs_busy", in_ready_a, !busy_a);
      if (dout_valid_a) begin
        if (sbq_a.size() == 0) begin
          fail_now("a_expected_bit");
        end else begin
          e = sbq_a.pop_front();
          check("a_dout", dout_a, e.b);
          check("a_frame_start", frame_start_a, e.s);
          check("a_frame_done", frame_done_a, e.d);
        end
      end else begin
        check("a_idle_dout", dout_a, 1'b0);
        check("a_idle_start", frame_start_a, 1'b0);
        check("a_idle_done", frame_done_a, 1'b0);
      end
      if (frame_done_a === 1'b1) begin
        last_done_a = cyc;
        done_cnt_a++;
      end
    end
  end

  // Scoreboard / protocol monitor, instance B
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (mon_en) begin
      check("b_ready_vs_busy", in_ready_b, !busy_b);
      if (dout_valid_b) begin
        if (sbq_b.size() == 0) begin
          fail_now("b_expected_bit");
        end else begin
          e = sbq_b.pop_front();
          check("b_dout", dout_b, e.b);
          check("b_frame_start", frame_start_b, e.s);
          check("b_frame_done", frame_done_b, e.d);
        end
      end else begin
        check("b_idle_dout", dout_b, 1'b0);
        check("b_idle_done", frame_done_b, 1'b0);
      end
      if (frame_start_b === 1'b1 && lb_en) begin
        if (prev_start_b >= 0) check("b_frame_period", cyc - prev_start_b, 7);
        prev_start_b = cyc;
      end
    end
  end

  // 10010 detector models on the valid bits of each stream; history clears
  // between frames since every frame is followed by at least one idle cycle.
  logic [4:0] hist_a = '0, hist_b = '0;
  int vidx_a = 0, vidx_b = 0;

  always @(negedge clk) begin : det_model
    if (!dout_valid_a) begin
      hist_a = '0; vidx_a = 0;
    end else begin
      hist_a = {hist_a[3:0], dout_a}; vidx_a++;
      if (lb_en && vidx_a >= 5 && hist_a == 5'b10010) begin
        det_a++;
        check("a_detect_pos", vidx_a, 5);
      end
    end
    if (!dout_valid_b) begin
      hist_b = '0; vidx_b = 0;
    end else begin
      hist_b = {hist_b[3:0], dout_b}; vidx_b++;
      if (lb_en && vidx_b >= 5 && hist_b == 5'b10010) begin
        det_b++;
        check("b_detect_pos", vidx_b, 5);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    vec_t vecs[6];
    int   n;
    int   done_snap;
    logic [7:0] d8;
    logic [0:0] d1;

    vecs[0] = '{data: 8'hA5, stream: 13'b10010_10100101};
    vecs[1] = '{data: 8'hFF, stream: 13'b10010_11111111};
    vecs[2] = '{data: 8'h00, stream: 13'b10010_00000000};
    vecs[3] = '{data: 8'h3C, stream: 13'b10010_00111100};
    vecs[4] = '{data: 8'h81, stream: 13'b10010_10000001};
    vecs[5] = '{data: 8'h5A, stream: 13'b10010_01011010};

    in_data_a = '0; in_valid_a = 1'b0;
    in_data_b = '0; in_valid_b = 1'b0;
    reset = 1'b0;
    #1 mon_en = 1'b1;

    // Reset held for 3 cycles, then 10 idle cycles
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready_a, 1'b1);
    check("rst_busy", busy_a, 1'b0);
    check("rst_dout", dout_a, 1'b0);
    check("rst_dout_valid", dout_valid_a, 1'b0);
    check("rst_frame_start", frame_start_a, 1'b0);
    check("rst_frame_done", frame_done_a, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("idle_in_ready", in_ready_a, 1'b1);
      check("idle_busy", busy_a, 1'b0);
      check("idle_dout_valid", dout_valid_a, 1'b0);
    end

    // Table-driven single frames; also checks GAP+1 cycles from frame_done to in_ready
    for (int i = 0; i < 6; i++) begin
      send_a(vecs[i].data, vecs[i].stream);
      wait_idle_a();
      check("tbl_done_to_ready", cyc - last_done_a, 3);
    end

    // Back-to-back with in_valid held high
    in_data_a  = 8'hFF;
    in_valid_a = 1'b1;
    check("b2b_ready_first", in_ready_a, 1'b1);
    push_a(13'b10010_11111111);
    $display("tx_a accept data=ff cycle=%0d (back-to-back)", cyc);
    @(posedge clk); #1;
    in_data_a = 8'h00;
    push_a(13'b10010_00000000);
    n = 0;
    while (!in_ready_a && n < 100) begin
      n++; @(posedge clk); #1;
    end
    check("b2b_busy_cycles", n, 15);
    check("b2b_accept_after_done", cyc - last_done_a, 3);
    $display("tx_a accept data=00 cycle=%0d (back-to-back)", cyc);
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    wait_idle_a();

    // Held data: in_data scrambled every cycle while busy
    send_a(8'h3C, 13'b10010_00111100);
    for (int i = 0; i < 16; i++) begin
      in_data_a = 8'($urandom);
      @(posedge clk); #1;
    end
    wait_idle_a();

    // Mid-frame reset during payload bit 4, then a clean 8'h81 frame
    done_snap = done_cnt_a;
    send_a(8'hA5, 13'b10010_10100101);
    repeat (8) begin @(posedge clk); #1; end
    check("abort_pre_valid", dout_valid_a, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("abort_dout", dout_a, 1'b0);
    check("abort_dout_valid", dout_valid_a, 1'b0);
    check("abort_busy", busy_a, 1'b0);
    check("abort_in_ready", in_ready_a, 1'b1);
    sbq_a.delete();
    $display("tx_a abort by reset cycle=%0d", cyc);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("abort_no_frame_done", done_cnt_a, done_snap);
    send_a(8'h81, 13'b10010_10000001);
    wait_idle_a();

    // Loopback on the 8-bit instance: payloads that do not create a second 10010
    lb_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      int tries = 0;
      d8 = 8'($urandom);
      while (count_pat({5'b10010, d8}) != 1 && tries < 1000) begin
        d8 = 8'($urandom); tries++;
      end
      send_a(d8, {5'b10010, d8});
      wait_idle_a();
    end
    check("a_detect_count", det_a, 20);

    // Loopback on the 1-bit/no-gap instance, in_valid held for minimum period
    in_valid_b = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d1 = 1'($urandom);
      in_data_b = d1;
      n = 0;
      while (!in_ready_b && n < 50) begin
        @(posedge clk); #1; n++;
      end
      if (!in_ready_b) begin
        fail_now("b_accept_timeout");
      end else begin
        push_b({5'b10010, d1});
        $display("tx_b accept data=%0d cycle=%0d", d1, cyc);
        @(posedge clk); #1;
      end
    end
    in_valid_b = 1'b0;
    n = 0;
    while ((busy_b || sbq_b.size() != 0) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (busy_b || sbq_b.size() != 0) fail_now("b_idle_timeout");
    check("b_detect_count", det_b, 20);
    lb_en = 1'b0;

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_10010_frame_tx.md
Name: seq_10010_frame_tx

Overview:
- Serial frame transmitter: accepts a parallel payload word over a valid/ready handshake.
- Emits a 1-bit stream per frame: sync word 10010 (MSB first), then the payload (MSB first), then an idle gap of zeros.
- Drives the serial links that the team's 10010 sequence detectors monitor.
- Supplies frame-start and frame-done strobes for the surrounding control logic.

Parameters:
- PAYLOAD_W, 8, payload width in bits; legal range 1..32.
- GAP_CYCLES, 2, idle zero cycles after each frame; 0 allowed; legal range 0..255.
- SYNC_W, 5, sync word length; fixed, not for override.
- SYNC_WORD, 5'b10010, sync pattern, transmitted MSB first; fixed, not for override.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  PAYLOAD_W  payload word to transmit.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- dout  output  1  serial bit stream.
- dout_valid  output  1  dout carries a sync or payload bit this cycle.
- frame_start  output  1  one-cycle pulse coincident with the first sync bit.
- frame_done  output  1  one-cycle pulse coincident with the last payload bit.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset low, asynchronous assert):
  - State goes to IDLE; payload shift register and counters clear.
  - dout, dout_valid, frame_start, frame_done and busy = 0; in_ready = 1.
  - Deassertion is synchronous to clk; the first edge after release evaluates normally.
- All outputs are registered except in_ready, which is decoded from state (IDLE -> 1, else 0).
- States: IDLE, SYNC, DATA, GAP.
- IDLE:
  - dout = 0, dout_valid = 0.
  - On a rising edge with in_valid & in_ready: capture in_data, go to SYNC, load the bit counter with SYNC_W-1.
  - Latency: the first sync bit appears on dout the cycle after acceptance.
- SYNC:
  - Shifts out SYNC_WORD MSB first, one bit per cycle, for 5 cycles: 1,0,0,1,0.
  - dout_valid = 1 throughout; frame_start = 1 only on the first sync cycle.
  - After the last sync bit, go to DATA and load the counter with PAYLOAD_W-1.
- DATA:
  - Shifts out the captured word MSB first, PAYLOAD_W cycles, dout_valid = 1.
  - frame_done = 1 on the final payload cycle.
  - Then go to GAP if GAP_CYCLES > 0, else to IDLE.
- GAP: dout = 0, dout_valid = 0 for GAP_CYCLES cycles, then IDLE.
- Throughput:
  - Accept occurs only in IDLE, so back-to-back frames are separated by GAP_CYCLES+1 non-valid cycles.
  - Minimum frame period = SYNC_W + PAYLOAD_W + GAP_CYCLES + 1 cycles.
- The captured word is held internally; changes to in_data while busy have no effect.
- in_valid while busy is ignored and not queued; the upstream source holds it until in_ready.
- A payload containing 10010 is transmitted unmodified; no stuffing. Aliasing is a system-level concern.
- Reset asserted mid-frame:
  - The frame is aborted immediately and all outputs go to reset values.
  - No frame_done is emitted; the in-flight word is discarded.
- Counter width: clog2(max(PAYLOAD_W, GAP_CYCLES, SYNC_W)) bits, minimum 1; no wrap within legal parameters.
- Out-of-range parameters are a compile-time error (elaboration assertion).

Decomposition:
- Shared package seq_frame_pkg holds:
  - SYNC_W and SYNC_WORD;
  - the state enum (IDLE, SYNC, DATA, GAP), 2-bit encoding 00/01/10/11;
  - a function returning counter width.
- One sub-module: piso_shift_reg, a parameterised width, load/shift, MSB-first parallel-in serial-out register.
  - Used for the payload.
  - The sync bits come from indexing the constant SYNC_WORD with the counter.

Test Plan:
- Reset then idle: reset low for 3 cycles, release, in_valid=0 for 10 cycles -> in_ready=1, busy=0, dout=0, dout_valid=0 every cycle.
- Single frame:
  - Stimulus: in_data=8'hA5, in_valid for 1 cycle, GAP_CYCLES=2.
  - dout over the next 13 cycles = 1,0,0,1,0,1,0,1,0,0,1,0,1, with dout_valid=1.
  - frame_start on cycle 1 and frame_done on cycle 13.
  - Then 2 gap cycles with dout=0, then in_ready=1.
- Back-to-back:
  - Stimulus: in_valid held high with 8'hFF then 8'h00.
  - Second acceptance occurs exactly 3 cycles after the first frame_done.
  - in_ready=0 for all 15 busy cycles; second payload is 8 zeros.
- Held data:
  - Stimulus: accept 8'h3C, then toggle in_data every cycle while busy.
  - Payload bits are still 0,0,1,1,1,1,0,0.
- Mid-frame reset:
  - Stimulus: assert reset during payload bit 4.
  - dout, dout_valid and busy drop asynchronously; no frame_done.
  - After release, a new 8'h81 frame transmits correctly.
- Loopback:
  - Stimulus: feed dout into a 10010 detector model, 20 random payloads with no 10010 substring.
  - Exactly one detection per frame, on the 5th sync bit.
  - Repeat with PAYLOAD_W=1 and GAP_CYCLES=0.
